// File: rtl/emmc_pattern_tester.sv
// Write/read-back pattern tester that drives an eMMC transfer state machine and scores each block pass.
// Optional watchdog: define EMMC_PATTERN_TESTER_TIMEOUT_EN to force a failing EVAL after 2^24-1 stalled cycles.
module emmc_pattern_tester #(
  parameter int BLK_BYTES   = 512,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic                         clk_core,
  input  logic                         rst_tk,
  input  logic                         run_i,
  output logic                         sm_we_o,
  output logic                         sm_start_o,
  output logic [7:0]                   sm_dat_o,
  input  logic [7:0]                   sm_dat_i,
  input  logic                         sm_dvalid_i,
  input  logic                         sm_ready_i,
  output logic                         busy_o,
  output logic [15:0]                  pass_cnt_o,
  output logic [15:0]                  err_cnt_o,
  output logic                         fail_o,
  output logic [$clog2(BLK_BYTES)-1:0] err_idx_o,
  output logic [2:0]                   dbg_state_o
);

  localparam int IW   = $clog2(BLK_BYTES);
  localparam int IDXW = IW + 1;
  localparam logic [IDXW-1:0] BLK_CNT = IDXW'(BLK_BYTES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_XFER = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_XFER = 3'd4,
    S_EVAL    = 3'd5
  } state_t;

  // Handshake: sm_start_o is held until the state machine reports busy (sm_ready_i=0);
  // each sm_dvalid_i pulse moves exactly one byte; sm_ready_i rising ends the transfer.

  state_t           state_q, state_d;
  logic             start_q, start_d;
  logic             we_q, we_d;
  logic             busy_q, busy_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [15:0]      pass_q, pass_d;
  logic [15:0]      err_q, err_d;
  logic             fail_q, fail_d;
  logic [IW-1:0]    err_idx_q, err_idx_d;
  logic             err_seen_q, err_seen_d;
  logic [15:0]      tally_q, tally_d;
  logic [7:0]       pat;

`ifdef EMMC_PATTERN_TESTER_TIMEOUT_EN
  logic [23:0]      wd_q, wd_d;
`endif

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign pat = 8'(idx_q) ^ pass_q[7:0];

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    we_d       = we_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    err_d      = err_q;
    fail_d     = fail_q;
    err_idx_d  = err_idx_q;
    err_seen_d = err_seen_q;
    tally_d    = tally_q;
    case (state_q)
      S_IDLE: begin
        if (run_i && sm_ready_i && !(STOP_ON_ERR && fail_q)) begin
          state_d = S_WR_REQ;
          start_d = 1'b1;
          we_d    = 1'b1;
          idx_d   = '0;
          tally_d = '0;
        end
      end
      S_WR_REQ: begin
        if (!sm_ready_i) begin
          state_d = S_WR_XFER;
          start_d = 1'b0;
        end
      end
      S_RD_REQ: begin
        if (!sm_ready_i) begin
          state_d = S_RD_XFER;
          start_d = 1'b0;
        end
      end
      S_WR_XFER, S_RD_XFER: begin
        if (sm_dvalid_i) begin
          if (idx_q < BLK_CNT) begin
            idx_d = idx_q + 1'b1;
            if (state_q == S_RD_XFER && sm_dat_i != pat) begin
              tally_d = sat_add(tally_q, 16'd1);
              if (!err_seen_q) begin
                err_seen_d = 1'b1;
                err_idx_d  = idx_q[IW-1:0];
              end
            end
          end else begin
            tally_d = sat_add(tally_q, 16'd1);
          end
        end
        // A strobe coinciding with the ready rise is already in idx_d, so it is not counted missing.
        if (sm_ready_i) begin
          tally_d = sat_add(tally_d, 16'(BLK_CNT - idx_d));
          if (state_q == S_WR_XFER) begin
            state_d = S_RD_REQ;
            start_d = 1'b1;
            we_d    = 1'b0;
            idx_d   = '0;
          end else begin
            state_d = S_EVAL;
          end
        end
      end
      S_EVAL: begin
        if (tally_q == 16'd0) begin
          pass_d = sat_add(pass_q, 16'd1);
        end else begin
          err_d  = sat_add(err_q, tally_q);
          fail_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        start_d = 1'b0;
        we_d    = 1'b0;
      end
    endcase

`ifdef EMMC_PATTERN_TESTER_TIMEOUT_EN
    if (state_q == S_IDLE || sm_dvalid_i || state_d != state_q) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + 24'd1;
    end
    if (state_q != S_IDLE && state_q != S_EVAL && wd_q == 24'hFFFFFF) begin
      state_d = S_EVAL;
      start_d = 1'b0;
      we_d    = 1'b0;
      tally_d = 16'(BLK_BYTES);
      wd_d    = '0;
    end
`endif

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_core or posedge rst_tk) begin
    if (rst_tk) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      idx_q      <= '0;
      pass_q     <= '0;
      err_q      <= '0;
      fail_q     <= 1'b0;
      err_idx_q  <= '0;
      err_seen_q <= 1'b0;
      tally_q    <= '0;
`ifdef EMMC_PATTERN_TESTER_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
      err_idx_q  <= err_idx_d;
      err_seen_q <= err_seen_d;
      tally_q    <= tally_d;
`ifdef EMMC_PATTERN_TESTER_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

  assign sm_we_o     = we_q;
  assign sm_start_o  = start_q;
  assign sm_dat_o    = pat;
  assign busy_o      = busy_q;
  assign pass_cnt_o  = pass_q;
  assign err_cnt_o   = err_q;
  assign fail_o      = fail_q;
  assign err_idx_o   = err_idx_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_emmc_pattern_tester.sv
// Bench for emmc_pattern_tester: the bench plays the eMMC state machine and scores passes with an arithmetic model.
// Two instances (STOP_ON_ERR=0 and =1) share one stimulus path selected by sel.
module tb_emmc_pattern_tester;
  localparam int BLK = 16;

  logic clk_core = 1'b0;
  logic rst_tk   = 1'b1;
  always #5 clk_core = ~clk_core;

  logic       sel    = 1'b0;
  logic       run    = 1'b0;
  logic       ready  = 1'b1;
  logic       dvalid = 1'b0;
  logic [7:0] dat_in = 8'h00;

  logic a_run, a_ready, a_dvalid, a_we, a_start, a_busy, a_fail;
  logic s_run, s_ready, s_dvalid, s_we, s_start, s_busy, s_fail;
  logic [7:0]  a_dat, s_dat;
  logic [15:0] a_pass, a_err, s_pass, s_err;
  logic [3:0]  a_eidx, s_eidx;
  logic [2:0]  a_st, s_st;

  assign a_run    = sel ? 1'b0 : run;
  assign a_ready  = sel ? 1'b1 : ready;
  assign a_dvalid = sel ? 1'b0 : dvalid;
  assign s_run    = sel ? run : 1'b0;
  assign s_ready  = sel ? ready : 1'b1;
  assign s_dvalid = sel ? dvalid : 1'b0;

  logic m_we, m_start, m_busy, m_fail;
  logic [7:0]  m_dat;
  logic [15:0] m_pass, m_err;
  logic [3:0]  m_eidx;
  logic [2:0]  m_st;
  assign m_we    = sel ? s_we    : a_we;
  assign m_start = sel ? s_start : a_start;
  assign m_busy  = sel ? s_busy  : a_busy;
  assign m_fail  = sel ? s_fail  : a_fail;
  assign m_dat   = sel ? s_dat   : a_dat;
  assign m_pass  = sel ? s_pass  : a_pass;
  assign m_err   = sel ? s_err   : a_err;
  assign m_eidx  = sel ? s_eidx  : a_eidx;
  assign m_st    = sel ? s_st    : a_st;

  emmc_pattern_tester #(.BLK_BYTES(BLK), .STOP_ON_ERR(1'b0)) dut (
    .clk_core(clk_core), .rst_tk(rst_tk), .run_i(a_run),
    .sm_we_o(a_we), .sm_start_o(a_start), .sm_dat_o(a_dat), .sm_dat_i(dat_in),
    .sm_dvalid_i(a_dvalid), .sm_ready_i(a_ready), .busy_o(a_busy),
    .pass_cnt_o(a_pass), .err_cnt_o(a_err), .fail_o(a_fail), .err_idx_o(a_eidx),
    .dbg_state_o(a_st)
  );

  emmc_pattern_tester #(.BLK_BYTES(BLK), .STOP_ON_ERR(1'b1)) dut_s (
    .clk_core(clk_core), .rst_tk(rst_tk), .run_i(s_run),
    .sm_we_o(s_we), .sm_start_o(s_start), .sm_dat_o(s_dat), .sm_dat_i(dat_in),
    .sm_dvalid_i(s_dvalid), .sm_ready_i(s_ready), .busy_o(s_busy),
    .pass_cnt_o(s_pass), .err_cnt_o(s_err), .fail_o(s_fail), .err_idx_o(s_eidx),
    .dbg_state_o(s_st)
  );

  int n_total = 0;
  int n_bad   = 0;

  int         exp_pass;
  int         exp_err;
  bit         exp_fail;
  int         exp_eidx;
  bit         eidx_seen;
  bit         drop_run;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int k);
    return 8'(k) ^ 8'(exp_pass);
  endfunction

  task automatic model_reset();
    exp_pass  = 0;
    exp_err   = 0;
    exp_fail  = 1'b0;
    exp_eidx  = 0;
    eidx_seen = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pass"}, 32'(m_pass), 0);
    chk({tag, "_err"},  32'(m_err), 0);
    chk({tag, "_fail"}, 32'(m_fail), 0);
    chk({tag, "_eidx"}, 32'(m_eidx), 0);
    chk({tag, "_busy"}, 32'(m_busy), 0);
    chk({tag, "_start"}, 32'(m_start), 0);
    chk({tag, "_we"},   32'(m_we), 0);
    chk({tag, "_dat"},  32'(m_dat), 0);
    chk({tag, "_state"}, 32'(m_st), 0);
  endtask

  task automatic do_reset();
    run = 1'b0; ready = 1'b1; dvalid = 1'b0;
    @(negedge clk_core);
    rst_tk = 1'b1;
    repeat (2) @(negedge clk_core);
    check_reset_outputs("reset");
    rst_tk = 1'b0;
    model_reset();
  endtask

  task automatic wait_start(output bit ok);
    int t;
    t = 0;
    while (m_start !== 1'b1 && t < 200) begin
      @(negedge clk_core);
      t++;
    end
    ok = (m_start === 1'b1);
    if (!ok) chk("start_timeout", 32'(m_start), 1);
  endtask

  // Acts as the eMMC state machine for one transaction of n byte strobes.
  task automatic xfer(input bit is_wr, input int n, input logic [15:0] cmask,
                      input bit same, output bit ok);
    logic [7:0] e;
    int gap;
    @(negedge clk_core);
    dvalid = 1'b0;
    wait_start(ok);
    if (!ok) return;
    chk(is_wr ? "we_wr" : "we_rd", 32'(m_we), 32'(is_wr));
    chk("busy_in_pass", 32'(m_busy), 1);
    ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(negedge clk_core);
        dvalid = 1'b0;
      end
      @(negedge clk_core);
      if (k == 0) chk("start_dropped", 32'(m_start), 0);
      dvalid = 1'b1;
      if (is_wr) begin
        if (k < BLK) begin
          e = exp_q.pop_front();
          chk("wr_byte", 32'(m_dat), 32'(e));
        end
        if (drop_run && k == 1) run = 1'b0;
      end else begin
        dat_in = pat(k);
        if (k < BLK && cmask[k]) dat_in = dat_in ^ 8'($urandom_range(1, 255));
      end
      if (same && k == n - 1) ready = 1'b1;
    end
    if (!(same && n > 0)) begin
      @(negedge clk_core);
      dvalid = 1'b0;
      ready  = 1'b1;
    end
  endtask

  task automatic run_pass(input int nwr, input int nrd, input logic [15:0] cmask, input bit same);
    bit ok;
    int tally;
    int mism;
    int first;
    exp_q.delete();
    for (int k = 0; k < BLK; k++) exp_q.push_back(pat(k));
    xfer(1'b1, nwr, 16'h0, same, ok);
    if (!ok) return;
    xfer(1'b0, nrd, cmask, same, ok);
    if (!ok) return;
    @(negedge clk_core);
    dvalid = 1'b0;
    @(negedge clk_core);
    mism  = 0;
    first = -1;
    for (int k = 0; k < BLK && k < nrd; k++) begin
      if (cmask[k]) begin
        mism++;
        if (first < 0) first = k;
      end
    end
    tally = ((nwr > BLK) ? nwr - BLK : BLK - nwr) + ((nrd > BLK) ? nrd - BLK : BLK - nrd) + mism;
    if (tally == 0) exp_pass++;
    else begin
      exp_err += tally;
      exp_fail = 1'b1;
    end
    if (!eidx_seen && first >= 0) begin
      eidx_seen = 1'b1;
      exp_eidx  = first;
    end
    chk("pass_cnt", 32'(m_pass), 32'(exp_pass));
    chk("err_cnt",  32'(m_err),  32'(exp_err));
    chk("fail",     32'(m_fail), 32'(exp_fail));
    chk("err_idx",  32'(m_eidx), 32'(exp_eidx));
  endtask

  task automatic count_starts(input int cycles, output int seen);
    seen = 0;
    for (int t = 0; t < cycles; t++) begin
      @(negedge clk_core);
      if (m_start === 1'b1) seen++;
    end
  endtask

  initial begin
    int nwr, nrd, seen;
    logic [15:0] cm;
    bit ok;
    drop_run = 1'b0;
    model_reset();

    // Ideal passes, then targeted corruption, overrun and underrun.
    do_reset();
    run = 1'b1;
    for (int p = 0; p < 3; p++) run_pass(BLK, BLK, 16'h0, 1'b0);
    run_pass(BLK, BLK, 16'h0020, 1'b0);
    run_pass(BLK, 18, 16'h0, 1'b0);
    run_pass(BLK, 14, 16'h0, 1'b1);
    run_pass(14, BLK, 16'h0, 1'b0);

    // Randomised passes.
    for (int p = 0; p < 20; p++) begin
      nwr = ($urandom_range(0, 1) == 0) ? BLK : $urandom_range(BLK - 2, BLK + 2);
      nrd = ($urandom_range(0, 1) == 0) ? BLK : $urandom_range(BLK - 2, BLK + 2);
      cm  = ($urandom_range(0, 3) == 0) ? 16'(1 << $urandom_range(0, BLK - 1)) : 16'h0;
      run_pass(nwr, nrd, cm, 1'($urandom_range(0, 1)));
    end

    // run drops during the write transfer: the pass finishes and no new one starts.
    do_reset();
    run = 1'b1;
    drop_run = 1'b1;
    run_pass(BLK, BLK, 16'h0, 1'b0);
    drop_run = 1'b0;
    chk("drop_busy", 32'(m_busy), 0);
    count_starts(20, seen);
    chk("drop_no_restart", 32'(seen), 0);

    // Reset in the middle of the read transfer.
    do_reset();
    run = 1'b1;
    exp_q.delete();
    for (int k = 0; k < BLK; k++) exp_q.push_back(pat(k));
    xfer(1'b1, BLK, 16'h0, 1'b0, ok);
    @(negedge clk_core);
    wait_start(ok);
    ready = 1'b0;
    @(negedge clk_core);
    dvalid = 1'b1;
    dat_in = pat(0);
    @(negedge clk_core);
    dvalid = 1'b0;
    chk("mid_rd_state", 32'(m_st), 4);
    rst_tk = 1'b1;
    run = 1'b0;
    @(negedge clk_core);
    check_reset_outputs("mid_rst");
    rst_tk = 1'b0;
    ready = 1'b1;
    model_reset();

    // STOP_ON_ERR instance halts after its first failing pass.
    do_reset();
    sel = 1'b1;
    run = 1'b1;
    run_pass(BLK, BLK, 16'h0, 1'b0);
    run_pass(BLK, BLK, 16'h0008, 1'b0);
    count_starts(30, seen);
    chk("stop_no_restart", 32'(seen), 0);
    chk("stop_busy", 32'(m_busy), 0);
    run = 1'b0;
    @(negedge clk_core);
    sel = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL global_timeout: got running want finished");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
